pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Every cycle it generates the per-stage enable and flush controls. It covers load-use stalls, taken-branch flushes, and the two-cycle 32-bit stack accesses used for the SP and PC. It also runs the multi-cycle interrupt entry sequence: drain, push PC high and low words, push CCR, load vector. It is instantiated once in the processor top, beside the forwarding unit.

Parameters:
REG_NUM_W, 4, width of register-number fields (matches pipeline register dst-num width)
DRAIN_CYCLES, 3, bubble cycles inserted before interrupt pushes so in-flight instructions retire
CNT_W, 16, width of performance counters (used only with PERF_COUNTERS_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_NUM_W  destination register of instruction in EX
if_id_rs  in  REG_NUM_W  source 1 of instruction in ID
if_id_rt  in  REG_NUM_W  source 2 of instruction in ID
if_id_rs_used  in  1  source 1 is read
if_id_rt_used  in  1  source 2 is read
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_mem_two_word  in  1  instruction in MEM is a 32-bit access (first word this cycle)
interrupt_req  in  1  external interrupt, level or pulse, latched internally
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads bubble (zero controls)
id_ex_en  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_en  out  1  EX/MEM write enable
mem_wb_flush  out  1  MEM/WB loads bubble
int_seq_sel  out  2  0 normal, 1 push PC high, 2 push PC low, 3 push CCR
pc_vector_sel  out  1  PC loads interrupt vector this cycle
int_ack  out  1  one-cycle pulse, interrupt entry complete

Behaviour:
- Reset (reset=0 at posedge): state=RUN, int_pending=0, drain counter=0. While reset is low, all enables=0, flushes=0, int_seq_sel=0, pc_vector_sel=0, int_ack=0.
- Outputs are combinational from state and inputs. State, int_pending and counter are registered.
- int_pending sets on any cycle with interrupt_req=1. It clears only in the cycle int_ack=1. A request arriving in the int_ack cycle re-sets it (set wins).
- RUN, default: all enables=1, flushes=0. Conditions are evaluated in priority order; only the highest-priority match acts:
  1. ex_mem_two_word=1: go to MEM_WORD2. This cycle, pc_en, if_id_en, id_ex_en and ex_mem_en are 0; the stall occurs here.
  2. ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_en=1. Stay in RUN.
  3. Load-use hazard: id_ex_mem_read=1 and ((rs_used and rs==id_ex_rd) or (rt_used and rt==id_ex_rd)). Then pc_en=0, if_id_en=0, id_ex_flush=1. The stall is one cycle; stay in RUN.
  4. int_pending=1: go to INT_DRAIN with counter=0.
- MEM_WORD2: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_flush=0, so the second word completes. Next state is RUN. A branch or hazard pending in the frozen stages is re-evaluated in RUN.
- INT_DRAIN: pc_en=0, if_id_flush=1, downstream enables=1. The counter increments each cycle. When counter reaches DRAIN_CYCLES-1, go to PUSH_HI. A taken branch during drain is ignored, because fetch is frozen and the return PC is the held PC.
- PUSH_HI (int_seq_sel=1), then PUSH_LO (2), then PUSH_CCR (3): one cycle each. pc_en=0 and if_id_flush=1 throughout.
- VECTOR: pc_en=1, pc_vector_sel=1, if_id_flush=1, int_ack=1. Next state is RUN.
- An interrupt arriving during any non-RUN state only sets int_pending. It is serviced after the next return to RUN.
- Reset low in any state aborts the sequence immediately. Pending interrupts are lost.

Optional Feature:
PERF_COUNTERS_EN defined:
- Adds outputs stall_cycles[CNT_W] and flush_events[CNT_W]. Both reset to 0 and saturate at all-ones.
- stall_cycles increments every cycle in which pc_en=0.
- flush_events increments every cycle in which if_id_flush or id_ex_flush is 1.
PERF_COUNTERS_EN undefined: the ports and logic are absent.

Decomposition:
- Shared package pipeline_pkg holds the state enum (RUN, MEM_WORD2, INT_DRAIN, PUSH_HI, PUSH_LO, PUSH_CCR, VECTOR), the int_seq_sel encodings, and the REG_NUM_W default.
- One sub-module: load_use_detector. It is combinational and contains the hazard compare only.

Test Plan:
- Load R3, then add using R3 as rs: exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Control returns to normal the next cycle. No stall if rs_used=0.
- Taken branch in EX: if_id_flush=1 and id_ex_flush=1 in the same cycle, pc_en=1, no extra cycles.
- ex_mem_two_word coinciding with a load-use hazard and ex_branch_taken: a two-cycle freeze of PC through EX/MEM. Branch and hazard then act in RUN on the following cycle.
- interrupt_req pulse in RUN: 3 drain cycles, then int_seq_sel 1,2,3, then pc_vector_sel=1 and int_ack=1. Total 7 cycles; int_pending clears.
- interrupt_req during PUSH_LO: the current sequence completes. A second full sequence starts one cycle after returning to RUN.
- reset=0 during PUSH_HI: next cycle, state RUN with all outputs at reset values. With PERF_COUNTERS_EN, the counters read 0 and saturate at 16'hFFFF under a forced long stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states,
// interrupt push-select encodings and the default register-number width.
package pipeline_pkg;

    localparam int unsigned REG_NUM_W_DEF = 4;

    typedef enum logic [2:0] {
        RUN,
        MEM_WORD2,
        INT_DRAIN,
        PUSH_HI,
        PUSH_LO,
        PUSH_CCR,
        VECTOR
    } state_t;

    localparam logic [1:0] SEQ_NORMAL = 2'd0;
    localparam logic [1:0] SEQ_PC_HI  = 2'd1;
    localparam logic [1:0] SEQ_PC_LO  = 2'd2;
    localparam logic [1:0] SEQ_CCR    = 2'd3;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detector
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_NUM_W = REG_NUM_W_DEF
) (
    input  logic                 mem_read,
    input  logic [REG_NUM_W-1:0] ex_rd,
    input  logic [REG_NUM_W-1:0] rs,
    input  logic [REG_NUM_W-1:0] rt,
    input  logic                 rs_used,
    input  logic                 rt_used,
    output logic                 hazard
);

    always_comb begin
        hazard = mem_read && ((rs_used && (rs == ex_rd)) || (rt_used && (rt == ex_rd)));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Per-stage enable/flush sequencer: load-use stalls, branch flushes, two-word
// MEM freezes and interrupt entry. Optional PERF_COUNTERS_EN adds stall/flush counters.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_NUM_W    = REG_NUM_W_DEF,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_ex_mem_read,
    input  logic [REG_NUM_W-1:0] id_ex_rd,
    input  logic [REG_NUM_W-1:0] if_id_rs,
    input  logic [REG_NUM_W-1:0] if_id_rt,
    input  logic                 if_id_rs_used,
    input  logic                 if_id_rt_used,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mem_two_word,
    input  logic                 interrupt_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_flush,
    output logic [1:0]           int_seq_sel,
    output logic                 pc_vector_sel,
    output logic                 int_ack
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    state_t            state, state_next;
    logic              int_pending, int_pending_next;
    logic [DCNT_W-1:0] drain_cnt, drain_cnt_next;
    logic              load_use;

    load_use_detector #(
        .REG_NUM_W (REG_NUM_W)
    ) u_load_use (
        .mem_read (id_ex_mem_read),
        .ex_rd    (id_ex_rd),
        .rs       (if_id_rs),
        .rt       (if_id_rt),
        .rs_used  (if_id_rs_used),
        .rt_used  (if_id_rt_used),
        .hazard   (load_use)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            int_pending <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            state       <= state_next;
            int_pending <= int_pending_next;
            drain_cnt   <= drain_cnt_next;
        end
    end

    // A request in the acknowledge cycle re-arms pending (set wins over clear).
    always_comb begin
        state_next       = state;
        drain_cnt_next   = '0;
        int_pending_next = interrupt_req | (int_pending & ~int_ack);
        case (state)
            RUN: begin
                if (ex_mem_two_word)      state_next = MEM_WORD2;
                else if (ex_branch_taken) state_next = RUN;
                else if (load_use)        state_next = RUN;
                else if (int_pending)     state_next = INT_DRAIN;
            end
            MEM_WORD2: state_next = RUN;
            INT_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_next = PUSH_HI;
                else                         drain_cnt_next = drain_cnt + 1'b1;
            end
            PUSH_HI:  state_next = PUSH_LO;
            PUSH_LO:  state_next = PUSH_CCR;
            PUSH_CCR: state_next = VECTOR;
            VECTOR:   state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_flush  = 1'b0;
        int_seq_sel   = SEQ_NORMAL;
        pc_vector_sel = 1'b0;
        int_ack       = 1'b0;
        if (reset) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            case (state)
                RUN: begin
                    if (ex_mem_two_word) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WORD2: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end
                INT_DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
                PUSH_HI: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    int_seq_sel = SEQ_PC_HI;
                end
                PUSH_LO: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    int_seq_sel = SEQ_PC_LO;
                end
                PUSH_CCR: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    int_seq_sel = SEQ_CCR;
                end
                VECTOR: begin
                    pc_vector_sel = 1'b1;
                    if_id_flush   = 1'b1;
                    int_ack       = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if ((if_id_flush || id_ex_flush) && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller; expected control
// words are hand-computed constants.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_mem_read;
    logic [3:0] id_ex_rd, if_id_rs, if_id_rt;
    logic       if_id_rs_used, if_id_rt_used;
    logic       ex_branch_taken, ex_mem_two_word, interrupt_req;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic [1:0] int_seq_sel;
    logic       pc_vector_sel, int_ack;
`ifdef PERF_COUNTERS_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_NUM_W    (4),
        .DRAIN_CYCLES (3),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_rs_used   (if_id_rs_used),
        .if_id_rt_used   (if_id_rt_used),
        .ex_branch_taken (ex_branch_taken),
        .ex_mem_two_word (ex_mem_two_word),
        .interrupt_req   (interrupt_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_flush    (mem_wb_flush),
        .int_seq_sel     (int_seq_sel),
        .pc_vector_sel   (pc_vector_sel),
        .int_ack         (int_ack)
`ifdef PERF_COUNTERS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, int_seq_sel, pc_vector_sel, int_ack}
    localparam logic [10:0] ZERO  = 11'b0_0_0_0_0_0_0_00_0_0;
    localparam logic [10:0] RUNN  = 11'b1_1_0_1_0_1_0_00_0_0;
    localparam logic [10:0] BR    = 11'b1_1_1_1_1_1_0_00_0_0;
    localparam logic [10:0] LU    = 11'b0_0_0_1_1_1_0_00_0_0;
    localparam logic [10:0] FRZ   = 11'b0_0_0_0_0_0_0_00_0_0;
    localparam logic [10:0] DRAIN = 11'b0_1_1_1_0_1_0_00_0_0;
    localparam logic [10:0] PHI   = 11'b0_1_1_1_0_1_0_01_0_0;
    localparam logic [10:0] PLO   = 11'b0_1_1_1_0_1_0_10_0_0;
    localparam logic [10:0] PCCR  = 11'b0_1_1_1_0_1_0_11_0_0;
    localparam logic [10:0] VEC   = 11'b1_1_1_1_0_1_0_00_1_1;

    logic [10:0] ctl;
    always_comb ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                       mem_wb_flush, int_seq_sel, pc_vector_sel, int_ack};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are already applied; settle, check, then advance one clock.
    task automatic cyc(input string tag, input logic [10:0] exp);
        #1;
        check(tag, {21'd0, ctl}, {21'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_ex_mem_read  = 1'b0;
        id_ex_rd        = 4'd0;
        if_id_rs        = 4'd0;
        if_id_rt        = 4'd0;
        if_id_rs_used   = 1'b0;
        if_id_rt_used   = 1'b0;
        ex_branch_taken = 1'b0;
        ex_mem_two_word = 1'b0;
        interrupt_req   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        ex_branch_taken = 1'b1;
        cyc("reset_outputs", ZERO);
        ex_branch_taken = 1'b0;
        reset = 1'b1;
        cyc("idle_run", RUNN);

        // load R3 in EX, R3 read as rs in ID
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd3; if_id_rs = 4'd3; if_id_rs_used = 1'b1;
        cyc("load_use_rs", LU);
        id_ex_mem_read = 1'b0;
        cyc("after_load_use", RUNN);
        id_ex_mem_read = 1'b1; if_id_rs_used = 1'b0;
        cyc("rs_unused", RUNN);
        if_id_rt = 4'd3; if_id_rt_used = 1'b1;
        cyc("load_use_rt", LU);
        if_id_rt = 4'd4;
        cyc("rt_differs", RUNN);
        idle_inputs();

        ex_branch_taken = 1'b1;
        cyc("branch_taken", BR);
        ex_branch_taken = 1'b0;
        cyc("after_branch", RUNN);

        // two-word access coinciding with branch and load-use
        ex_mem_two_word = 1'b1; ex_branch_taken = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd5; if_id_rs = 4'd5; if_id_rs_used = 1'b1;
        cyc("two_word_first", FRZ);
        ex_mem_two_word = 1'b0;
        cyc("two_word_second", FRZ);
        cyc("branch_after_freeze", BR);
        ex_branch_taken = 1'b0;
        cyc("hazard_after_freeze", LU);
        idle_inputs();
        cyc("run_after_freeze", RUNN);

        // interrupt pulse
        interrupt_req = 1'b1;
        cyc("irq_latch", RUNN);
        interrupt_req = 1'b0;
        cyc("irq_pending_run", RUNN);
        cyc("drain0", DRAIN);
        ex_branch_taken = 1'b1;
        cyc("drain1_branch_ignored", DRAIN);
        ex_branch_taken = 1'b0;
        cyc("drain2", DRAIN);
        cyc("push_hi", PHI);
        cyc("push_lo", PLO);
        cyc("push_ccr", PCCR);
        cyc("vector", VEC);
        cyc("after_ack", RUNN);
        cyc("pending_cleared", RUNN);

        // second request arriving during PUSH_LO, held through acknowledge
        interrupt_req = 1'b1;
        cyc("irq2_latch", RUNN);
        interrupt_req = 1'b0;
        cyc("irq2_pending", RUNN);
        repeat (3) cyc("irq2_drain", DRAIN);
        cyc("irq2_push_hi", PHI);
        interrupt_req = 1'b1;
        cyc("irq2_push_lo", PLO);
        cyc("irq2_push_ccr", PCCR);
        cyc("irq2_vector", VEC);
        interrupt_req = 1'b0;
        cyc("irq3_run", RUNN);
        repeat (3) cyc("irq3_drain", DRAIN);
        cyc("irq3_push_hi", PHI);
        cyc("irq3_push_lo", PLO);
        cyc("irq3_push_ccr", PCCR);
        cyc("irq3_vector", VEC);
        cyc("irq3_done", RUNN);

        // reset in the middle of the sequence
        interrupt_req = 1'b1;
        cyc("irq4_latch", RUNN);
        interrupt_req = 1'b0;
        cyc("irq4_pending", RUNN);
        repeat (3) cyc("irq4_drain", DRAIN);
        #1;
        check("irq4_push_hi", {21'd0, ctl}, {21'd0, PHI});
        reset = 1'b0;
        cyc("reset_in_push_hi", ZERO);
        reset = 1'b1;
        cyc("run_after_abort", RUNN);
        cyc("pending_lost", RUNN);

`ifdef PERF_COUNTERS_EN
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("stall_reset", {16'd0, stall_cycles}, 32'd0);
        check("flush_reset", {16'd0, flush_events}, 32'd0);
        ex_branch_taken = 1'b1;
        cyc("perf_branch", BR);
        ex_branch_taken = 1'b0;
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd7; if_id_rs = 4'd7; if_id_rs_used = 1'b1;
        cyc("perf_load_use", LU);
        #1;
        check("stall_count", {16'd0, stall_cycles}, 32'd1);
        check("flush_count", {16'd0, flush_events}, 32'd2);
        repeat (65600) @(posedge clk);
        #1;
        check("stall_saturate", {16'd0, stall_cycles}, 32'h0000FFFF);
        check("flush_saturate", {16'd0, flush_events}, 32'h0000FFFF);
        idle_inputs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
